// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Fixed DM priority with a starvation guard for IF; IDLE/ISSUE/WAIT/RESP sequencing.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_DM  = 1'b1;
  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              grant_if, grant_dm;

  // IF wins a contested IDLE cycle only once DM has been granted STARVE_MAX times in a row.
  assign grant_if = if_req & (~dm_req | (starve_q >= STARVE_LIM));
  assign grant_dm = dm_req & ~grant_if;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          owner_d     = OWN_DM;
          mem_en_d    = 1'b1;
          mem_wen_d   = dm_wen;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          starve_d    = (if_req && starve_q != 4'hF) ? starve_q + 4'd1 : (if_req ? starve_q : 4'd0);
          state_d     = S_ISSUE;
        end else if (grant_if) begin
          owner_d     = OWN_IF;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          starve_d    = 4'd0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_wen_q) begin
          dm_done_d = (owner_q == OWN_DM);
          if_done_d = (owner_q == OWN_IF);
          state_d   = S_RESP;
        end else begin
          wcnt_d  = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          // The only edge on which read data is sampled from the memory.
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            dm_rdata_d = mem_rdata;
            dm_done_d  = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      wcnt_q      <= 4'd0;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);

endmodule
